// File: rtl/chronos_arb_pkg.sv
// chronos_arb_pkg: shared encodings for the chronos memory arbiter
// (FSM states, transaction owner codes, default fetch byte-enable mask).
package chronos_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Wide enough for any sensible DATA_W; users slice the low DATA_W/8 bits.
  localparam int                  MAX_BE_W = 64;
  localparam logic [MAX_BE_W-1:0] BE_ALL   = {MAX_BE_W{1'b1}};

endpackage

// File: rtl/chronos_arb_pick.sv
// chronos_arb_pick: combinational winner selection between the fetch (IF)
// and load/store (LSU) requesters. RR_MODE=0 gives LSU priority unless the
// starvation guard fires; RR_MODE=1 alternates on ties using the last grant.
module chronos_arb_pick
  import chronos_arb_pkg::*;
#(
  parameter bit RR_MODE = 1'b0
) (
  input  logic i_if_valid,
  input  logic i_lsu_valid,
  input  logic i_starve_hit,
  input  logic i_last_lsu,
  output logic o_grant_if,
  output logic o_grant_lsu
);

  logic w_tie_lsu;

  // Decide who takes a tie: the not-last-granted side, or LSU unless IF is starving
  always_comb begin
    w_tie_lsu = 1'b1;
    if (RR_MODE) begin
      w_tie_lsu = ~i_last_lsu;
    end else begin
      w_tie_lsu = ~i_starve_hit;
    end
  end

  // Grant the sole requester, or the tie winner when both are valid
  always_comb begin
    o_grant_if  = 1'b0;
    o_grant_lsu = 1'b0;
    case ({i_if_valid, i_lsu_valid})
      2'b01: o_grant_lsu = 1'b1;
      2'b10: o_grant_if  = 1'b1;
      2'b11: begin
        if (w_tie_lsu) begin
          o_grant_lsu = 1'b1;
        end else begin
          o_grant_if = 1'b1;
        end
      end
      default: begin
        o_grant_if  = 1'b0;
        o_grant_lsu = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/chronos_mem_arbiter.sv
// chronos_mem_arbiter: shares one memory port between instruction fetch and
// load/store, one transaction in flight. Define CHRONOS_ARB_RR_EN to replace
// the LSU-priority/starvation-guard policy with strict round-robin.
module chronos_mem_arbiter
  import chronos_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_req_we,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_be,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_be,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                arb_err
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_req_valid;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic w_grant_if;
  logic w_grant_lsu;
  logic w_starve_hit;
  logic w_last_lsu;
  logic w_idle;
  logic w_route;
  logic w_stray;

`ifdef CHRONOS_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
  logic r_last_lsu;
  assign w_starve_hit = 1'b0;
  assign w_last_lsu   = r_last_lsu;
`else
  localparam bit              RR_MODE = 1'b0;
  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] r_starve_cnt;
  assign w_starve_hit = (r_starve_cnt == LIMIT_C);
  assign w_last_lsu   = 1'b0;
`endif

  chronos_arb_pick #(.RR_MODE(RR_MODE)) u_pick (
    .i_if_valid   (if_req_valid),
    .i_lsu_valid  (lsu_req_valid),
    .i_starve_hit (w_starve_hit),
    .i_last_lsu   (w_last_lsu),
    .o_grant_if   (w_grant_if),
    .o_grant_lsu  (w_grant_lsu)
  );

  assign w_idle  = (r_state == IDLE);
  // A response counts only once the request has been accepted (same cycle or later).
  assign w_route = mem_rsp_valid & ((r_state == WAIT_RSP) | ((r_state == ISSUE) & mem_req_ready));
  assign w_stray = mem_rsp_valid & ((r_state == IDLE) | ((r_state == ISSUE) & ~mem_req_ready));

  // Request readies and response routing, all forced low while reset is asserted
  always_comb begin
    if_req_ready  = 1'b0;
    lsu_req_ready = 1'b0;
    if_rsp_valid  = 1'b0;
    lsu_rsp_valid = 1'b0;
    if_rsp_data   = {DATA_W{1'b0}};
    lsu_rsp_data  = {DATA_W{1'b0}};
    if (rst) begin
      if_req_ready  = w_idle & w_grant_if;
      lsu_req_ready = w_idle & w_grant_lsu;
      if_rsp_valid  = w_route & (r_owner == OWN_IF);
      lsu_rsp_valid = w_route & (r_owner == OWN_LSU);
      if_rsp_data   = mem_rsp_data;
      lsu_rsp_data  = mem_rsp_data;
    end else begin
      if_req_ready  = 1'b0;
      lsu_req_ready = 1'b0;
    end
  end

  // Arbitration FSM: grant capture, memory issue, response wait, error and fairness state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_be        <= {BE_W{1'b0}};
`ifdef CHRONOS_ARB_RR_EN
      r_last_lsu  <= 1'b0;
`else
      r_starve_cnt <= {CNT_W{1'b0}};
`endif
    end else begin
      if (w_stray) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_grant_lsu) begin
            r_state     <= ISSUE;
            r_owner     <= OWN_LSU;
            r_req_valid <= 1'b1;
            r_we        <= lsu_req_we;
            r_addr      <= lsu_req_addr;
            r_wdata     <= lsu_req_wdata;
            r_be        <= lsu_req_be;
`ifdef CHRONOS_ARB_RR_EN
            r_last_lsu  <= 1'b1;
`else
            if (if_req_valid) begin
              r_starve_cnt <= w_starve_hit ? r_starve_cnt : (r_starve_cnt + CNT_W'(1));
            end else begin
              r_starve_cnt <= {CNT_W{1'b0}};
            end
`endif
          end else if (w_grant_if) begin
            r_state     <= ISSUE;
            r_owner     <= OWN_IF;
            r_req_valid <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= if_req_addr;
            r_wdata     <= {DATA_W{1'b0}};
            r_be        <= BE_ALL[BE_W-1:0];
`ifdef CHRONOS_ARB_RR_EN
            r_last_lsu  <= 1'b0;
`else
            r_starve_cnt <= {CNT_W{1'b0}};
`endif
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= mem_rsp_valid ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_be    = r_be;
  assign arb_err       = r_err;

endmodule

// File: tb/tb_chronos_mem_arbiter.sv
// tb_chronos_mem_arbiter: scoreboard bench for chronos_mem_arbiter with a
// behavioural memory (programmable ready/response delays, stray-pulse injection).
module tb_chronos_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [3:0]  lsu_req_be;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, arb_err;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_be;

  chronos_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_be(lsu_req_be),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lsu;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  mreq_t       mem_exp_q[$];
  mreq_t       lsu_src_q[$];
  logic [31:0] if_src_q[$];
  logic [31:0] if_rsp_q[$];
  logic [31:0] lsu_rsp_q[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_delay = 0;
  int          rsp_delay = 1;
  int          m_phase = 0;
  int          m_wait = 0;
  int          m_rspw = 0;
  int          gcount = 0;
  logic [15:0] grant_bits = 16'h0;
  logic [1:0]  exp_own = 2'd0;
  logic        busy = 1'b0;
  logic        exp_err = 1'b0;
  logic        err_pending = 1'b0;
  logic        stray_req = 1'b0;
  mreq_t       cur;

`ifdef CHRONOS_ARB_RR_EN
  localparam logic [15:0] STARVE_SEQ = 16'h0157;  // L I L I L I L L L
`else
  localparam logic [15:0] STARVE_SEQ = 16'h01EC;  // L L L L I L L I I
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_if(input logic [31:0] a);
    if_src_q.push_back(a);
  endtask

  task automatic push_lsu(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mreq_t r;
    r.lsu = 1'b1; r.we = we; r.addr = a; r.wdata = d; r.be = be;
    lsu_src_q.push_back(r);
  endtask

  task automatic req_drive();
    if_req_valid  = (if_src_q.size() != 0);
    if_req_addr   = (if_src_q.size() != 0) ? if_src_q[0] : 32'h0;
    lsu_req_valid = (lsu_src_q.size() != 0);
    if (lsu_src_q.size() != 0) begin
      lsu_req_we = lsu_src_q[0].we; lsu_req_addr = lsu_src_q[0].addr;
      lsu_req_wdata = lsu_src_q[0].wdata; lsu_req_be = lsu_src_q[0].be;
    end else begin
      lsu_req_we = 1'b0; lsu_req_addr = 32'h0; lsu_req_wdata = 32'h0; lsu_req_be = 4'h0;
    end
  endtask

  task automatic issue_rsp();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = cur.we ? 32'h0 : (cur.addr + 32'h3);
    exp_own       = cur.lsu ? 2'd2 : 2'd1;
  endtask

  task automatic mem_drive();
    mreq_t e;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; exp_own = 2'd0;
    if (m_phase == 0) begin
      if (mem_req_valid) begin
        check_eq("mem_req_expected", (mem_exp_q.size() != 0), 1'b1);
        if (mem_exp_q.size() != 0) begin
          e = mem_exp_q[0];
          check_eq("mem_req_we", mem_req_we, e.we);
          check_eq("mem_req_addr", mem_req_addr, e.addr);
          check_eq("mem_req_be", mem_req_be, e.be);
          if (e.we) check_eq("mem_req_wdata", mem_req_wdata, e.wdata);
          if (m_wait >= ready_delay) begin
            mem_req_ready = 1'b1;
            cur = mem_exp_q.pop_front();
            m_wait = 0;
            if (rsp_delay == 0) begin
              issue_rsp();
            end else begin
              m_phase = 1; m_rspw = 1;
            end
          end else begin
            m_wait++;
          end
        end
      end else if (stray_req) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_0000;
        stray_req = 1'b0; err_pending = 1'b1;
      end
    end else begin
      if (m_rspw >= rsp_delay) begin
        issue_rsp();
        m_phase = 0;
      end else begin
        m_rspw++;
      end
    end
  endtask

  task automatic observe();
    mreq_t r;
    if (busy) begin
      check_eq("if_req_ready_busy", if_req_ready, 1'b0);
      check_eq("lsu_req_ready_busy", lsu_req_ready, 1'b0);
    end
    check_eq("if_rsp_valid", if_rsp_valid, (exp_own == 2'd1));
    check_eq("lsu_rsp_valid", lsu_rsp_valid, (exp_own == 2'd2));
    check_eq("arb_err", arb_err, exp_err);
    if (if_rsp_valid) begin
      check_eq("if_rsp_q_nonempty", (if_rsp_q.size() != 0), 1'b1);
      if (if_rsp_q.size() != 0) check_eq("if_rsp_data", if_rsp_data, if_rsp_q.pop_front());
    end
    if (lsu_rsp_valid) begin
      check_eq("lsu_rsp_q_nonempty", (lsu_rsp_q.size() != 0), 1'b1);
      if (lsu_rsp_q.size() != 0) check_eq("lsu_rsp_data", lsu_rsp_data, lsu_rsp_q.pop_front());
    end
    if (exp_own != 2'd0) busy = 1'b0;
    if (if_req_valid && if_req_ready) begin
      r.lsu = 1'b0; r.we = 1'b0; r.addr = if_src_q.pop_front(); r.wdata = 32'h0; r.be = 4'hF;
      mem_exp_q.push_back(r);
      if_rsp_q.push_back(r.addr + 32'h3);
      grant_bits = {grant_bits[14:0], 1'b0}; gcount++; busy = 1'b1;
    end
    if (lsu_req_valid && lsu_req_ready) begin
      r = lsu_src_q.pop_front();
      mem_exp_q.push_back(r);
      lsu_rsp_q.push_back(r.we ? 32'h0 : (r.addr + 32'h3));
      grant_bits = {grant_bits[14:0], 1'b1}; gcount++; busy = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    if (err_pending) begin exp_err = 1'b1; err_pending = 1'b0; end
    req_drive();
    mem_drive();
    #1;
    observe();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((if_src_q.size() != 0 || lsu_src_q.size() != 0 || busy) && n < budget) begin
      cycle(); n++;
    end
    check_eq("run_timeout", (n >= budget), 1'b0);
    cycle();
    check_eq("if_rsp_left", if_rsp_q.size(), 0);
    check_eq("lsu_rsp_left", lsu_rsp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_valid"}, mem_req_valid, 1'b0);
    check_eq({tag, "_mem_we"}, mem_req_we, 1'b0);
    check_eq({tag, "_mem_addr"}, mem_req_addr, 32'h0);
    check_eq({tag, "_mem_wdata"}, mem_req_wdata, 32'h0);
    check_eq({tag, "_mem_be"}, mem_req_be, 4'h0);
    check_eq({tag, "_arb_err"}, arb_err, 1'b0);
    check_eq({tag, "_if_ready"}, if_req_ready, 1'b0);
    check_eq({tag, "_lsu_ready"}, lsu_req_ready, 1'b0);
    check_eq({tag, "_if_rsp_valid"}, if_rsp_valid, 1'b0);
    check_eq({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 32'h0; lsu_req_wdata = 32'h0; lsu_req_be = 4'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0;
    #12;
    check_all_zero("reset");
    if_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk); rst = 1'b1;

    // IF alone, memory answers one cycle after ready
    ready_delay = 0; rsp_delay = 1; grant_bits = 16'h0; gcount = 0;
    push_if(32'h0000_0010);
    run_until_idle(20);
    check_eq("s1_grants", gcount, 1);
    check_eq("s1_seq", grant_bits[0], 1'b0);

    // Simultaneous store and fetch: LSU first, IF in the next IDLE
    grant_bits = 16'h0; gcount = 0;
    push_lsu(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3);
    push_if(32'h0000_0200);
    run_until_idle(30);
    check_eq("s2_grants", gcount, 2);
    check_eq("s2_seq", grant_bits[1:0], 2'b10);

    // Continuous LSU with IF pending; zero-latency memory response path
    rsp_delay = 0; grant_bits = 16'h0; gcount = 0;
    for (int i = 0; i < 6; i++) push_lsu(1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) push_if(32'h0000_2000 + 32'(i * 4));
    run_until_idle(80);
    check_eq("s3_grants", gcount, 9);
    check_eq("s3_seq", grant_bits & 16'h01FF, STARVE_SEQ);

    // Memory holds ready low for 5 cycles while IF waits behind the store
    rsp_delay = 1; ready_delay = 5;
    push_lsu(1'b1, 32'h0000_0300, 32'h1234_5678, 4'hC);
    n = 0;
    while (!busy && n < 10) begin cycle(); n++; end
    check_eq("s4_accept_timeout", busy, 1'b1);
    push_if(32'h0000_0400);
    run_until_idle(60);
    ready_delay = 0;

    // Stray response while idle sets the sticky error
    stray_req = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("s5_err_sticky", arb_err, 1'b1);

    // Reset in the middle of WAIT_RSP
    rsp_delay = 4;
    push_if(32'h0000_0040);
    n = 0;
    while (m_phase == 0 && n < 20) begin cycle(); n++; end
    check_eq("s6_issue_timeout", (m_phase == 1), 1'b1);
    cycle();
    if_req_valid = 1'b1; if_req_addr = 32'h44;
    #1 rst = 1'b0;
    #1 check_all_zero("midreset");
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
    #1 check_eq("midreset_if_rsp", if_rsp_valid, 1'b0);
    check_eq("midreset_lsu_rsp", lsu_rsp_valid, 1'b0);
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    if_req_valid = 1'b0;
    mem_exp_q.delete(); if_rsp_q.delete(); lsu_rsp_q.delete(); if_src_q.delete(); lsu_src_q.delete();
    busy = 1'b0; m_phase = 0; m_wait = 0; exp_err = 1'b0; err_pending = 1'b0; stray_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    rsp_delay = 1; gcount = 0;
    push_if(32'h0000_0020);
    run_until_idle(20);
    check_eq("s6_grants", gcount, 1);
    check_eq("s6_err_clear", arb_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
